cache_read: RTL and testbench

- Read-side controller of the L1 data cache: direct-mapped, 64 sets, 16-byte lines, 22-bit tags.
- Serves core loads; a hit returns data from the tag/data arrays.
- A miss fetches the whole line from memory as 4 word reads, refills the arrays, sets the line valid bit, then returns the load result.
- Sits between the core and the CPU wrapper memory port, alongside cache_write, which handles stores write-through.

---
 rtl/cache_read_pkg.sv | 38 +++
 rtl/cache_read_load_extract.sv | 28 ++
 rtl/cache_read.sv | 168 ++++++++++++++++
 tb/tb_cache_read.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_read_pkg.sv
// Shared types and constants for the L1 data cache read controller.
package cache_read_pkg;

  localparam int unsigned TAG_BITS    = 22;
  localparam int unsigned INDEX_BITS  = 6;
  localparam int unsigned OFFSET_BITS = 4;
  localparam int unsigned LINE_WORDS  = 4;
  localparam int unsigned WORD_BITS   = 32;
  localparam int unsigned LINE_BITS   = LINE_WORDS * WORD_BITS;
  localparam int unsigned CNT_BITS    = OFFSET_BITS - 2;
  localparam int unsigned TYPE_BITS   = 3;
  localparam int unsigned BE_BITS     = LINE_BITS / 8;

  localparam logic [TYPE_BITS-1:0] CACHE_BYTE    = 3'b000;
  localparam logic [TYPE_BITS-1:0] CACHE_HWORD   = 3'b001;
  localparam logic [TYPE_BITS-1:0] CACHE_WORD    = 3'b010;
  localparam logic [TYPE_BITS-1:0] CACHE_BYTE_U  = 3'b100;
  localparam logic [TYPE_BITS-1:0] CACHE_HWORD_U = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_CHECK,
    ST_FILL,
    ST_REFILL,
    ST_RESPOND
  } state_e;

  typedef struct packed {
    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] idx;
    logic [CNT_BITS-1:0]   word;
    logic [1:0]            boff;
  } addr_t;

  typedef logic [LINE_WORDS-1:0][WORD_BITS-1:0] line_t;

endpackage

// File: rtl/cache_read_load_extract.sv
// Selects and extends a byte/halfword/word from a 32-bit word for a load.
module cache_read_load_extract
  import cache_read_pkg::*;
(
  input  logic [WORD_BITS-1:0] word_i,
  input  logic [1:0]           boff_i,
  input  logic [TYPE_BITS-1:0] type_i,
  output logic [WORD_BITS-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{boff_i, 3'b000} +: 8];
    half_sel = boff_i[1] ? word_i[31:16] : word_i[15:0];
    data_o   = '0;
    case (type_i)
      CACHE_BYTE:    data_o = {{24{byte_sel[7]}}, byte_sel};
      CACHE_HWORD:   data_o = {{16{half_sel[15]}}, half_sel};
      CACHE_WORD:    data_o = word_i;
      CACHE_BYTE_U:  data_o = {24'h0, byte_sel};
      CACHE_HWORD_U: data_o = {16'h0, half_sel};
      default:       data_o = '0;
    endcase
  end

endmodule

// File: rtl/cache_read.sv
// L1 data cache read controller: direct-mapped lookup, 4-word line fill on miss,
// extended load result back to the core.
module cache_read
  import cache_read_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_BITS-1:0]  core_addr,
  input  logic                  core_req,
  input  logic                  core_write,
  input  logic [TYPE_BITS-1:0]  core_type,
  output logic [WORD_BITS-1:0]  core_out,
  output logic                  core_wait,
  output logic                  D_req,
  output logic [WORD_BITS-1:0]  D_addr,
  output logic                  D_write,
  output logic [TYPE_BITS-1:0]  D_type,
  input  logic [WORD_BITS-1:0]  D_out,
  input  logic                  D_wait,
  output logic [INDEX_BITS-1:0] index,
  output logic [TAG_BITS-1:0]   TA_in,
  output logic                  TA_write,
  output logic                  TA_read,
  input  logic [TAG_BITS-1:0]   TA_out,
  output logic [LINE_BITS-1:0]  DA_in,
  output logic [BE_BITS-1:0]    DA_write,
  output logic                  DA_read,
  input  logic [LINE_BITS-1:0]  DA_out,
  input  logic                  valid_data_from_register,
  output logic                  valid_write,
  output logic                  valid_read
);

  state_e                 state_q, state_d;
  addr_t                  addr_q, addr_d;
  logic [TYPE_BITS-1:0]   type_q, type_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic                   gap_q, gap_d;
  line_t                  line_q, line_d;

  line_t                  da_line;
  logic [WORD_BITS-1:0]   ext_word;
  logic [WORD_BITS-1:0]   ext_data;
  logic                   resp_en;

  assign da_line = DA_out;
  assign D_write = 1'b0;
  assign D_type  = CACHE_WORD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      type_q  <= '0;
      cnt_q   <= '0;
      gap_q   <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    type_d      = type_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    line_d      = line_q;
    core_wait   = 1'b0;
    D_req       = 1'b0;
    D_addr      = '0;
    index       = '0;
    TA_in       = '0;
    TA_write    = 1'b0;
    TA_read     = 1'b0;
    DA_in       = '0;
    DA_write    = '1;
    DA_read     = 1'b0;
    valid_write = 1'b0;
    valid_read  = 1'b0;
    ext_word    = '0;
    resp_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (core_req && !core_write) begin
          addr_d    = addr_t'(core_addr);
          type_d    = core_type;
          core_wait = 1'b1;
          state_d   = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        core_wait  = 1'b1;
        index      = addr_q.idx;
        TA_read    = 1'b1;
        DA_read    = 1'b1;
        valid_read = 1'b1;
        state_d    = ST_CHECK;
      end
      ST_CHECK: begin
        index = addr_q.idx;
        if (valid_data_from_register && (TA_out == addr_q.tag)) begin
          ext_word = da_line[addr_q.word];
          resp_en  = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          core_wait = 1'b1;
          cnt_d     = '0;
          gap_d     = 1'b0;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        core_wait = 1'b1;
        index     = addr_q.idx;
        // One idle cycle between word reads so the memory sees a fresh request.
        if (gap_q) begin
          gap_d = 1'b0;
        end else begin
          D_req  = 1'b1;
          D_addr = {addr_q.tag, addr_q.idx, cnt_q, 2'b00};
          if (!D_wait) begin
            line_d[cnt_q] = D_out;
            if (cnt_q == CNT_BITS'(LINE_WORDS - 1)) begin
              state_d = ST_REFILL;
            end else begin
              cnt_d = CNT_BITS'(cnt_q + 1'b1);
              gap_d = 1'b1;
            end
          end
        end
      end
      ST_REFILL: begin
        core_wait   = 1'b1;
        index       = addr_q.idx;
        TA_write    = 1'b1;
        TA_in       = addr_q.tag;
        DA_write    = '0;
        DA_in       = line_q;
        valid_write = 1'b1;
        state_d     = ST_RESPOND;
      end
      ST_RESPOND: begin
        ext_word = line_q[addr_q.word];
        resp_en  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  cache_read_load_extract u_extract (
    .word_i (ext_word),
    .boff_i (addr_q.boff),
    .type_i (type_q),
    .data_o (ext_data)
  );

  assign core_out = resp_en ? ext_data : '0;

endmodule

// File: tb/tb_cache_read.sv
// Directed bench for cache_read with behavioural tag/data/valid arrays and memory.
module tb_cache_read;
  import cache_read_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] core_addr = '0;
  logic        core_req = 1'b0;
  logic        core_write = 1'b0;
  logic [2:0]  core_type = '0;
  logic [31:0] core_out;
  logic        core_wait;
  logic        D_req;
  logic [31:0] D_addr;
  logic        D_write;
  logic [2:0]  D_type;
  logic [31:0] D_out;
  logic        D_wait;
  logic [5:0]  index;
  logic [21:0] TA_in;
  logic        TA_write;
  logic        TA_read;
  logic [21:0] TA_out = '0;
  logic [127:0] DA_in;
  logic [15:0] DA_write;
  logic        DA_read;
  logic [127:0] DA_out = '0;
  logic        valid_data_from_register;
  logic        valid_write;
  logic        valid_read;

  logic [21:0]  tag_mem  [64] = '{default: '0};
  logic [127:0] data_mem [64] = '{default: '0};
  logic [63:0]  valid_vec = '0;
  logic [1:0]   wcnt;

  int          n_acc = 0, n_taw = 0, n_vw = 0, n_act = 0, n_const_bad = 0;
  logic [31:0] acc_addr [64];
  logic [21:0] last_tag = '0;
  logic [5:0]  last_idx = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cache_read dut (
    .clk(clk), .rst(rst),
    .core_addr(core_addr), .core_req(core_req), .core_write(core_write),
    .core_type(core_type), .core_out(core_out), .core_wait(core_wait),
    .D_req(D_req), .D_addr(D_addr), .D_write(D_write), .D_type(D_type),
    .D_out(D_out), .D_wait(D_wait),
    .index(index), .TA_in(TA_in), .TA_write(TA_write), .TA_read(TA_read),
    .TA_out(TA_out), .DA_in(DA_in), .DA_write(DA_write), .DA_read(DA_read),
    .DA_out(DA_out), .valid_data_from_register(valid_data_from_register),
    .valid_write(valid_write), .valid_read(valid_read)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_1230: return 32'h0000_00A0;
      32'h0000_1234: return 32'h0000_00A1;
      32'h0000_1238: return 32'h0000_00A2;
      32'h0000_123C: return 32'h0000_00A3;
      32'h0000_0014: return 32'h80FF_7F80;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory answers each request after two busy cycles.
  assign D_wait = D_req && (wcnt != 2'd2);
  assign D_out  = (D_req && !D_wait) ? mem_word(D_addr) : 32'h0;
  assign valid_data_from_register = valid_vec[index];

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 2'd0;
    else if (D_req) wcnt <= D_wait ? wcnt + 2'd1 : 2'd0;
  end

  always @(posedge clk) begin
    if (TA_read) TA_out <= tag_mem[index];
    if (DA_read) DA_out <= data_mem[index];
    if (TA_write) tag_mem[index] <= TA_in;
    for (int b = 0; b < 16; b++)
      if (!DA_write[b]) data_mem[index][8*b +: 8] <= DA_in[8*b +: 8];
    if (valid_write) valid_vec[index] <= 1'b1;
  end

  always @(posedge clk) begin
    if (D_req && !D_wait) begin
      if (n_acc < 64) acc_addr[n_acc] = D_addr;
      n_acc++;
    end
    if (TA_write) begin
      n_taw++;
      last_tag = TA_in;
      last_idx = index;
    end
    if (valid_write) n_vw++;
    if (D_req || TA_read || DA_read || valid_read || TA_write || valid_write || DA_write != 16'hffff)
      n_act++;
    if (D_write !== 1'b0 || D_type !== CACHE_WORD) n_const_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] t,
                         output logic [31:0] d, output int lat);
    logic zero_ok;
    @(negedge clk);
    core_addr = a; core_type = t; core_write = 1'b0; core_req = 1'b1;
    #1;
    check("accept_wait", 32'(core_wait), 32'd1);
    zero_ok = 1'b1;
    lat = 0;
    @(posedge clk);
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (!core_wait) break;
      if (core_out != 32'h0) zero_ok = 1'b0;
    end
    d = core_out;
    core_req = 1'b0;
    check("out_zero_while_wait", 32'(zero_ok), 32'd1);
  endtask

  logic [31:0] d;
  int          lat, b_acc, b_taw, b_vw, b_act, k;

  typedef struct { logic [31:0] a; logic [2:0] t; logic [31:0] exp; } vec_t;
  vec_t ext_vecs [9];

  initial begin
    ext_vecs[0] = '{32'h14, CACHE_BYTE,    32'hFFFF_FF80};
    ext_vecs[1] = '{32'h14, CACHE_BYTE_U,  32'h0000_0080};
    ext_vecs[2] = '{32'h16, CACHE_HWORD,   32'hFFFF_80FF};
    ext_vecs[3] = '{32'h16, CACHE_HWORD_U, 32'h0000_80FF};
    ext_vecs[4] = '{32'h14, CACHE_HWORD,   32'h0000_7F80};
    ext_vecs[5] = '{32'h15, CACHE_BYTE,    32'h0000_007F};
    ext_vecs[6] = '{32'h17, CACHE_BYTE,    32'hFFFF_FF80};
    ext_vecs[7] = '{32'h16, CACHE_WORD,    32'h80FF_7F80};
    ext_vecs[8] = '{32'h14, 3'b011,        32'h0000_0000};

    // Reset values
    #2 rst = 1'b1;
    #1;
    check("rst_core_wait", 32'(core_wait), 32'd0);
    check("rst_core_out", core_out, 32'd0);
    check("rst_d_req", 32'(D_req), 32'd0);
    check("rst_da_write", 32'(DA_write), 32'h0000_FFFF);
    check("rst_d_type", 32'(D_type), 32'(CACHE_WORD));
    check("rst_ta_write", 32'(TA_write), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Cold miss
    b_acc = n_acc; b_taw = n_taw; b_vw = n_vw;
    do_load(32'h0000_1234, CACHE_WORD, d, lat);
    check("cold_data", d, 32'h0000_00A1);
    check("cold_latency", 32'(lat), 32'd19);
    check("cold_nreq", 32'(n_acc - b_acc), 32'd4);
    for (int i = 0; i < 4; i++)
      check("cold_fill_addr", acc_addr[b_acc + i], 32'h0000_1230 + 32'(i * 4));
    check("cold_ntaw", 32'(n_taw - b_taw), 32'd1);
    check("cold_tag", 32'(last_tag), 32'h4);
    check("cold_idx", 32'(last_idx), 32'h23);
    check("cold_nvalid", 32'(n_vw - b_vw), 32'd1);

    // Hit after fill
    b_acc = n_acc; b_taw = n_taw;
    do_load(32'h0000_1234, CACHE_WORD, d, lat);
    check("hit_data", d, 32'h0000_00A1);
    check("hit_latency", 32'(lat), 32'd2);
    check("hit_nreq", 32'(n_acc - b_acc), 32'd0);
    check("hit_ntaw", 32'(n_taw - b_taw), 32'd0);

    // Extension: miss result from the line buffer, then hits
    do_load(32'h0000_0016, CACHE_HWORD, d, lat);
    check("ext_miss_data", d, 32'hFFFF_80FF);
    check("ext_miss_latency", 32'(lat), 32'd19);
    for (int i = 0; i < 9; i++) begin
      do_load(ext_vecs[i].a, ext_vecs[i].t, d, lat);
      check("ext_data", d, ext_vecs[i].exp);
      check("ext_latency", 32'(lat), 32'd2);
    end

    // Conflict miss in set 1
    b_acc = n_acc;
    do_load(32'h0000_0410, CACHE_WORD, d, lat);
    check("conf_data", d, 32'h5A5A_0410);
    check("conf_latency", 32'(lat), 32'd19);
    check("conf_first_addr", acc_addr[b_acc], 32'h0000_0410);
    check("conf_tag", 32'(last_tag), 32'h1);
    check("conf_idx", 32'(last_idx), 32'h1);
    do_load(32'h0000_0014, CACHE_BYTE, d, lat);
    check("conf_back_data", d, 32'hFFFF_FF80);
    check("conf_back_latency", 32'(lat), 32'd19);

    // Store ignored
    @(negedge clk);
    core_addr = 32'h0000_1234; core_type = CACHE_WORD; core_write = 1'b1; core_req = 1'b1;
    #1;
    check("store_wait", 32'(core_wait), 32'd0);
    b_act = n_act;
    repeat (3) @(negedge clk);
    check("store_wait_later", 32'(core_wait), 32'd0);
    check("store_activity", 32'(n_act - b_act), 32'd0);
    core_req = 1'b0; core_write = 1'b0;

    // Reset in the middle of a fill
    @(negedge clk);
    b_acc = n_acc; b_taw = n_taw; b_vw = n_vw;
    core_addr = 32'h0000_2000; core_type = CACHE_WORD; core_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    core_req = 1'b0;
    k = 0;
    while (k < 100 && (n_acc - b_acc) < 2) begin
      @(negedge clk);
      k++;
    end
    check("midfill_two_words", 32'(n_acc - b_acc), 32'd2);
    rst = 1'b1;
    #1;
    check("midfill_rst_wait", 32'(core_wait), 32'd0);
    check("midfill_rst_dreq", 32'(D_req), 32'd0);
    check("midfill_rst_daddr", D_addr, 32'd0);
    check("midfill_rst_da_write", 32'(DA_write), 32'h0000_FFFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midfill_no_taw", 32'(n_taw - b_taw), 32'd0);
    check("midfill_no_vw", 32'(n_vw - b_vw), 32'd0);
    b_acc = n_acc;
    do_load(32'h0000_2000, CACHE_WORD, d, lat);
    check("midfill_reload_data", d, 32'h5A5A_2000);
    check("midfill_reload_latency", 32'(lat), 32'd19);
    check("midfill_reload_nreq", 32'(n_acc - b_acc), 32'd4);

    check("d_write_type_const", 32'(n_const_bad), 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
